// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 note decoder
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_t;

    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;

    localparam int NUM_NOTES = 13;

    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_E = 8'h24;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_F = 8'h2B;
    localparam logic [7:0] KEY_T = 8'h2C;
    localparam logic [7:0] KEY_G = 8'h34;
    localparam logic [7:0] KEY_Y = 8'h35;
    localparam logic [7:0] KEY_H = 8'h33;
    localparam logic [7:0] KEY_U = 8'h3C;
    localparam logic [7:0] KEY_J = 8'h3B;
    localparam logic [7:0] KEY_K = 8'h42;

    // Keyboard housekeeping bytes (BAT, ACK, resend, errors) carry no key.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == BYTE_00) || (b == BYTE_AA) || (b == BYTE_FA) ||
               (b == BYTE_FE) || (b == BYTE_FF);
    endfunction

endpackage

// File: rtl/ps2_note_decoder_if.sv
// rtl/ps2_note_decoder_if.sv - receiver byte stream in, key events and note state out
interface ps2_note_decoder_if;
    import ps2_pkg::*;

    logic [7:0]           temp_data;
    logic [3:0]           num;
    logic                 neg_ps2k_clk;

    logic [3:0]           note;
    logic                 note_valid;
    logic [NUM_NOTES-1:0] held;
    logic                 key_evt;
    logic                 key_rel;
    logic                 ext_flag;
    logic [7:0]           scan_code;

    modport master (
        output temp_data, num, neg_ps2k_clk,
        input  note, note_valid, held, key_evt, key_rel, ext_flag, scan_code
    );

    modport slave (
        input  temp_data, num, neg_ps2k_clk,
        output note, note_valid, held, key_evt, key_rel, ext_flag, scan_code
    );

endinterface

// File: rtl/ps2_keymap.sv
// rtl/ps2_keymap.sv - set-2 make code to piano key index lookup
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0] scan_code,
    output logic       hit,
    output logic [3:0] idx
);

    always_comb begin
        hit = 1'b1;
        idx = 4'd0;
        case (scan_code)
            KEY_A:   idx = 4'd0;
            KEY_W:   idx = 4'd1;
            KEY_S:   idx = 4'd2;
            KEY_E:   idx = 4'd3;
            KEY_D:   idx = 4'd4;
            KEY_F:   idx = 4'd5;
            KEY_T:   idx = 4'd6;
            KEY_G:   idx = 4'd7;
            KEY_Y:   idx = 4'd8;
            KEY_H:   idx = 4'd9;
            KEY_U:   idx = 4'd10;
            KEY_J:   idx = 4'd11;
            KEY_K:   idx = 4'd12;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_note_decoder.sv
// rtl/ps2_note_decoder.sv - PS/2 scan code FSM producing key events and the sounding note
module ps2_note_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic                clk,
    input  logic                rst,
    ps2_note_decoder_if.slave   bus
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_t           state, state_n;
    logic [CW-1:0]        tmo_cnt;
    logic                 bstb;
    logic                 timeout;

    logic                 do_evt, is_brk, is_ext;
    logic                 map_hit;
    logic [3:0]           map_idx;
    logic [NUM_NOTES-1:0] held_r, held_clr;
    logic [3:0]           low_idx;

    logic [3:0]           note_r;
    logic                 note_valid_r;
    logic                 key_evt_r, key_rel_r, ext_flag_r;
    logic [7:0]           scan_code_r;

    // Stop-bit edge: the receiver's shift register holds the whole byte here.
    assign bstb    = bus.neg_ps2k_clk && (bus.num == 4'd10);
    assign timeout = (state != ST_IDLE) && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

    ps2_keymap u_keymap (
        .scan_code (bus.temp_data),
        .hit       (map_hit),
        .idx       (map_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        do_evt  = 1'b0;
        is_brk  = 1'b0;
        is_ext  = 1'b0;
        if (bstb) begin
            case (state)
                ST_IDLE: begin
                    if (bus.temp_data == BYTE_F0)      state_n = ST_BRK;
                    else if (bus.temp_data == BYTE_E0) state_n = ST_EXT;
                    else if (!is_ignored(bus.temp_data)) do_evt = 1'b1;
                end
                ST_BRK: begin
                    if (bus.temp_data != BYTE_F0) begin
                        do_evt  = 1'b1;
                        is_brk  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (bus.temp_data == BYTE_F0) begin
                        state_n = ST_EXT_BRK;
                    end else if (bus.temp_data != BYTE_E0) begin
                        do_evt  = 1'b1;
                        is_ext  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    do_evt  = 1'b1;
                    is_brk  = 1'b1;
                    is_ext  = 1'b1;
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_n = ST_IDLE;
        end
    end

    // Counter only runs while a prefix is pending; expiry forces IDLE so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst || bstb || state == ST_IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign held_clr = held_r & ~(NUM_NOTES'(1) << map_idx);

    always_comb begin
        low_idx = 4'd0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (held_clr[i]) low_idx = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            held_r       <= '0;
            note_r       <= '0;
            note_valid_r <= 1'b0;
            key_evt_r    <= 1'b0;
            key_rel_r    <= 1'b0;
            ext_flag_r   <= 1'b0;
            scan_code_r  <= '0;
        end else begin
            key_evt_r <= 1'b0;
            // A make of an already-held key is typematic repeat and is swallowed.
            if (do_evt && !(!is_brk && !is_ext && map_hit && held_r[map_idx])) begin
                key_evt_r   <= 1'b1;
                key_rel_r   <= is_brk;
                ext_flag_r  <= is_ext;
                scan_code_r <= bus.temp_data;
                if (!is_ext && map_hit) begin
                    if (!is_brk) begin
                        held_r[map_idx] <= 1'b1;
                        note_r          <= map_idx;
                        note_valid_r    <= 1'b1;
                    end else begin
                        held_r <= held_clr;
                        if (map_idx == note_r) begin
                            if (|held_clr) note_r       <= low_idx;
                            else           note_valid_r <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.note       = note_r;
    assign bus.note_valid = note_valid_r;
    assign bus.held       = held_r;
    assign bus.key_evt    = key_evt_r;
    assign bus.key_rel    = key_rel_r;
    assign bus.ext_flag   = ext_flag_r;
    assign bus.scan_code  = scan_code_r;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// tb/tb_ps2_note_decoder.sv - directed self-checking bench for ps2_note_decoder
module tb_ps2_note_decoder;

    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   evt_cnt = 0;
    int   snap;

    ps2_note_decoder_if bus ();

    ps2_note_decoder #(.TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.key_evt === 1'b1) evt_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle stop-bit strobe; returns at the negedge where the result is visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.temp_data    = b;
        bus.num          = 4'd10;
        bus.neg_ps2k_clk = 1'b1;
        @(negedge clk);
        bus.neg_ps2k_clk = 1'b0;
        bus.num          = 4'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_note"},  32'(bus.note), 0);
        chk({tag, "_nv"},    32'(bus.note_valid), 0);
        chk({tag, "_held"},  32'(bus.held), 0);
        chk({tag, "_evt"},   32'(bus.key_evt), 0);
        chk({tag, "_rel"},   32'(bus.key_rel), 0);
        chk({tag, "_ext"},   32'(bus.ext_flag), 0);
        chk({tag, "_scan"},  32'(bus.scan_code), 0);
    endtask

    initial begin
        bus.temp_data    = 8'h00;
        bus.num          = 4'd0;
        bus.neg_ps2k_clk = 1'b0;

        // Reset, with a byte arriving while reset is held.
        idle(2);
        send(8'h1C);
        idle(1);
        chk_all_zero("reset");
        rst = 1'b1;
        idle(2);

        // Press / release A
        send(8'h1C);
        chk("pressA_evt",  32'(bus.key_evt), 1);
        chk("pressA_rel",  32'(bus.key_rel), 0);
        chk("pressA_ext",  32'(bus.ext_flag), 0);
        chk("pressA_note", 32'(bus.note), 0);
        chk("pressA_nv",   32'(bus.note_valid), 1);
        chk("pressA_held", 32'(bus.held), 32'h0001);
        chk("pressA_scan", 32'(bus.scan_code), 32'h1C);
        idle(1);
        chk("pressA_pulse", 32'(bus.key_evt), 0);
        send(8'hF0);
        chk("prefix_noevt", 32'(bus.key_evt), 0);
        send(8'h1C);
        chk("relA_evt",  32'(bus.key_evt), 1);
        chk("relA_rel",  32'(bus.key_rel), 1);
        chk("relA_nv",   32'(bus.note_valid), 0);
        chk("relA_held", 32'(bus.held), 0);
        chk("relA_note", 32'(bus.note), 0);
        idle(2);

        // Chord with fallback to the lowest held key
        send(8'h1C); idle(1);
        send(8'h23); idle(1);
        send(8'h42);
        chk("chord_note", 32'(bus.note), 12);
        chk("chord_held", 32'(bus.held), 32'h1011);
        idle(1);
        send(8'hF0); send(8'h42);
        chk("brkK_note", 32'(bus.note), 0);
        chk("brkK_held", 32'(bus.held), 32'h0011);
        idle(1);
        send(8'hF0); send(8'h1C);
        chk("brkA_note", 32'(bus.note), 4);
        chk("brkA_nv",   32'(bus.note_valid), 1);
        idle(1);
        send(8'hF0); send(8'h23);
        chk("brkD_nv",   32'(bus.note_valid), 0);
        chk("brkD_note", 32'(bus.note), 4);
        chk("brkD_held", 32'(bus.held), 0);
        idle(2);

        // Typematic repeat
        snap = evt_cnt;
        repeat (5) begin
            send(8'h1C);
            idle(1);
        end
        idle(1);
        chk("typem_evts", 32'(evt_cnt - snap), 1);
        chk("typem_held", 32'(bus.held), 32'h0001);
        send(8'hF0); send(8'h1C);
        idle(2);

        // Unmapped make and ignored housekeeping byte
        send(8'h15);
        chk("unmap_evt",  32'(bus.key_evt), 1);
        chk("unmap_scan", 32'(bus.scan_code), 32'h15);
        chk("unmap_nv",   32'(bus.note_valid), 0);
        chk("unmap_held", 32'(bus.held), 0);
        idle(2);
        snap = evt_cnt;
        send(8'hAA);
        idle(2);
        chk("ignore_evts", 32'(evt_cnt - snap), 0);

        // Extended make / break, including a mapped code behind E0
        send(8'hE0); send(8'h75);
        chk("extmk_evt",  32'(bus.key_evt), 1);
        chk("extmk_ext",  32'(bus.ext_flag), 1);
        chk("extmk_rel",  32'(bus.key_rel), 0);
        chk("extmk_scan", 32'(bus.scan_code), 32'h75);
        idle(1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("extbk_evt",  32'(bus.key_evt), 1);
        chk("extbk_ext",  32'(bus.ext_flag), 1);
        chk("extbk_rel",  32'(bus.key_rel), 1);
        chk("extbk_scan", 32'(bus.scan_code), 32'h75);
        chk("extbk_held", 32'(bus.held), 0);
        idle(1);
        send(8'hE0); send(8'h1C);
        chk("extA_ext",  32'(bus.ext_flag), 1);
        chk("extA_held", 32'(bus.held), 0);
        chk("extA_nv",   32'(bus.note_valid), 0);
        idle(2);

        // Prefix still pending just before the timeout: follow-up is a break
        send(8'hF0);
        idle(TMO - 4);
        send(8'h1C);
        chk("pre_tmo_rel",  32'(bus.key_rel), 1);
        chk("pre_tmo_held", 32'(bus.held), 0);
        idle(2);

        // Prefix abandoned after the timeout: follow-up is a make
        send(8'hF0);
        idle(TMO + 2);
        send(8'h1C);
        chk("tmo_evt",  32'(bus.key_evt), 1);
        chk("tmo_rel",  32'(bus.key_rel), 0);
        chk("tmo_note", 32'(bus.note), 0);
        chk("tmo_nv",   32'(bus.note_valid), 1);
        chk("tmo_held", 32'(bus.held), 32'h0001);
        idle(1);
        send(8'hF0); send(8'h1C);
        idle(2);

        // Reset in the middle of an E0 F0 sequence
        send(8'hE0); send(8'h75);
        idle(1);
        send(8'hE0); send(8'hF0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_all_zero("rstmid");
        idle(1);
        send(8'h1C);
        chk("rstmid_A_rel",  32'(bus.key_rel), 0);
        chk("rstmid_A_ext",  32'(bus.ext_flag), 0);
        chk("rstmid_A_note", 32'(bus.note), 0);
        chk("rstmid_A_nv",   32'(bus.note_valid), 1);
        chk("rstmid_A_held", 32'(bus.held), 32'h0001);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_note_decoder.md
# ps2_note_decoder

Consumes the byte stream produced by the PS/2 frame receiver (`temp_data`, `num`, `neg_ps2k_clk`) and turns PS/2 set-2 scan codes into piano key events. It handles the F0 break prefix, the E0 extended prefix, typematic repeats and stuck-prefix timeouts. It maintains a 13-key held vector and the currently sounding note for the tone generator downstream.

## Interface
- `TIMEOUT_CYC`, default 2_500_000 (50 ms at 50 MHz): cycles allowed between a prefix byte and its follow-up byte before the FSM abandons the sequence.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset. Synchronous, active-low.
- `temp_data`  in  8  data byte from the receiver. Stable once `num` reaches 9.
- `num`  in  4  receiver bit counter, 0..10.
- `neg_ps2k_clk`  in  1  receiver's one-cycle PS/2 falling-edge strobe.
- `note`  out  4  index of the sounding note, 0..12 (0 = C … 12 = high C).
- `note_valid`  out  1  a note is sounding.
- `held`  out  13  bit i set while note key i is held.
- `key_evt`  out  1  one-cycle pulse per accepted make/break.
- `key_rel`  out  1  qualifies `key_evt`: 1 = break, 0 = make.
- `ext_flag`  out  1  qualifies `key_evt`: the code was E0-prefixed.
- `scan_code`  out  8  code of the last `key_evt` (prefixes stripped).

## Operation
- Byte strobe `bstb` = `neg_ps2k_clk && num == 10`. This is the stop-bit edge, and `temp_data` holds the complete byte at that point.
- Keymap, make code → index:
  - 1C→0, 1D→1, 1B→2, 24→3, 23→4, 2B→5, 2C→6, 34→7, 35→8, 33→9, 3C→10, 3B→11, 42→12.
  - Keys in that order: A W S E D F T G Y H U J K.
  - Any other code is unmapped.
- FSM states and transitions on `bstb`:
  - IDLE: F0→BRK, E0→EXT. Bytes 00, AA, FA, FE, FF are ignored and the FSM stays in IDLE. Any other byte is a make, and the FSM stays in IDLE.
  - BRK: F0→BRK. Any other byte (including E0) is a break code, and the FSM goes to IDLE.
  - EXT: F0→EXT_BRK, E0→EXT. Any other byte is an extended make, and the FSM goes to IDLE.
  - EXT_BRK: any byte is an extended break, and the FSM goes to IDLE.
- Make, non-extended:
  - Mapped and `held[i]`=0: set `held[i]`, `note`←i, `note_valid`←1, pulse `key_evt` with `key_rel`=0.
  - Mapped and already held (typematic repeat): no event, no change.
  - Unmapped: pulse `key_evt` with `key_rel`=0, `ext_flag`=0. No note change.
- Break, non-extended:
  - Always pulse `key_evt` with `key_rel`=1.
  - If mapped: clear `held[i]`.
  - If i == `note` and other keys remain held: `note`←lowest remaining index.
  - If i == `note` and no keys remain held: `note_valid`←0 and `note` keeps its value.
  - Releasing a key that is not held is legal. The event pulses and the state does not change.
- Extended make/break: pulse `key_evt` with `ext_flag`=1. `held` and `note` never change.
- Timeout:
  - Counter clears on every `bstb` and whenever the FSM is in IDLE.
  - In any non-IDLE state, when the counter reaches `TIMEOUT_CYC-1` the FSM goes to IDLE on the next edge, with no event.

## Timing
- All outputs are registered.
- `bstb` at cycle T → state, `held`, `note`, `note_valid`, `scan_code`, `key_rel`, `ext_flag` and `key_evt` update at the edge ending T. They are visible in T+1.
- `key_evt` is high for exactly one cycle. `key_rel`, `ext_flag` and `scan_code` hold until the next event.
- Reset (`rst`=0 at an edge) sets every output to 0 and the FSM to IDLE. This overrides a simultaneous `bstb` and discards any partial prefix sequence.
- If `bstb` coincides with timeout expiry, the byte is processed in the current state and the timeout is discarded.
- Minimum byte spacing from PS/2 is ~1 ms, so no back-to-back `bstb` handling is required.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, BRK, EXT, EXT_BRK).
  - Byte constants: F0, E0, AA, FA, FE, 00, FF.
  - `NUM_NOTES`=13 and the 13 keymap scan-code constants.
- Sub-module `ps2_keymap`: combinational, `scan_code[7:0]` → `{hit, idx[3:0]}`.
- Top level: FSM, timeout counter, held vector, and a lowest-set-bit priority encoder.

## Test plan
- Press/release A: 1C, then F0 1C → `key_evt` with `key_rel`=0, `note`=0, `note_valid`=1, `held`=0x0001; then `key_evt` with `key_rel`=1, `note_valid`=0, `held`=0.
- Chord with fallback: make 1C, make 23, make 42 → `note`=12, `held`=0x1011. Break 42 → `note`=0. Break 1C → `note`=4. Break 23 → `note_valid`=0.
- Typematic: 1C sent five times → exactly one `key_evt`, `held`=0x0001.
- Extended: E0 75, then E0 F0 75 → two `key_evt` pulses with `ext_flag`=1, `scan_code`=75, `key_rel` 0 then 1. `held` stays 0.
- Timeout: F0, then idle for `TIMEOUT_CYC` cycles, then 1C → FSM back in IDLE; 1C is treated as a make, `note`=0.
- Reset mid-sequence: E0 F0, then `rst` low for one cycle, then 1C → all outputs cleared; 1C is treated as a non-extended make, `note`=0, `ext_flag`=0.
